// File: rtl/dclk_mon_pkg.sv
// Shared types and defaults for the divided-clock receive monitor.
package dclk_mon_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    MEAS = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam int unsigned DEF_W        = 4;
  localparam int unsigned DEF_EXP_HI   = 4;
  localparam int unsigned DEF_EXP_LO   = 2;
  localparam int unsigned DEF_LOCK_CNT = 2;
  localparam int unsigned RUN_MAX      = 2**DEF_W - 1;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dclk_monitor_edge_det.sv
// Registers the observed divided clock and flags 0->1 / 1->0 changes against it.
module edge_det (
  input  logic clk,
  input  logic rst_b,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  // Tracks unconditionally (also through clr) so a clear never fakes an edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) d_q <= 1'b0;
    else        d_q <= d;
  end

  always_comb begin
    rise = d & ~d_q;
    fall = ~d & d_q;
  end

endmodule

// File: rtl/dclk_monitor.sv
// Measures high/low run lengths of dclk_in, qualifies lock, flags sticky faults.
module dclk_monitor
  import dclk_mon_pkg::*;
#(
  parameter int unsigned W        = DEF_W,
  parameter int unsigned EXP_HI   = DEF_EXP_HI,
  parameter int unsigned EXP_LO   = DEF_EXP_LO,
  parameter int unsigned LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         clr,
  input  logic         c_up,
  input  logic         dclk_in,
  output logic         rise,
  output logic         fall,
  output logic [W-1:0] hi_len,
  output logic [W-1:0] lo_len,
  output logic         locked,
  output logic         err
);

  localparam int unsigned GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [W-1:0]  HI_V    = W'(EXP_HI);
  localparam logic [W-1:0]  LO_V    = W'(EXP_LO);
  localparam logic [W-1:0]  STUCK_V = W'(max_of(EXP_HI, EXP_LO));
  localparam logic [GW-1:0] LAST_G  = GW'(LOCK_CNT - 1);

  state_t        state;
  logic [W-1:0]  run_cnt;
  logic [GW-1:0] good_cnt;
  logic          hi_ok;
  logic          edge_r, edge_f, is_edge;

  edge_det u_edge (
    .clk  (clk),
    .rst_b(rst_b),
    .d    (dclk_in),
    .rise (edge_r),
    .fall (edge_f)
  );

  assign is_edge = edge_r | edge_f;
  assign locked  = (state == LOCK);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= SYNC;
      run_cnt  <= '0;
      good_cnt <= '0;
      hi_ok    <= 1'b0;
      hi_len   <= '0;
      lo_len   <= '0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      err      <= 1'b0;
    end else if (clr) begin
      state    <= SYNC;
      run_cnt  <= '0;
      good_cnt <= '0;
      hi_ok    <= 1'b0;
      hi_len   <= '0;
      lo_len   <= '0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      err      <= 1'b0;
    end else begin
      rise <= edge_r;
      fall <= edge_f;

      if (is_edge)                    run_cnt <= W'(1);
      else if (c_up && run_cnt != '1) run_cnt <= run_cnt + 1'b1;

      if (is_edge && !c_up) err <= 1'b1;

      unique case (state)
        SYNC: begin
          good_cnt <= '0;
          hi_ok    <= 1'b0;
          if (is_edge) state <= MEAS;
        end

        MEAS: begin
          if (edge_f) begin
            hi_len <= run_cnt;
            hi_ok  <= (run_cnt == HI_V);
          end else if (edge_r) begin
            lo_len <= run_cnt;
            hi_ok  <= 1'b0;
            // hi_ok is only ever set by a fall, so a rise straight after SYNC is bad.
            if (hi_ok && run_cnt == LO_V) begin
              good_cnt <= good_cnt + 1'b1;
              if (good_cnt == LAST_G) state <= LOCK;
            end else begin
              good_cnt <= '0;
            end
          end
        end

        LOCK: begin
          if (edge_f) begin
            hi_len <= run_cnt;
            hi_ok  <= (run_cnt == HI_V);
            if (run_cnt != HI_V) begin
              err      <= 1'b1;
              state    <= MEAS;
              good_cnt <= '0;
            end
          end else if (edge_r) begin
            lo_len <= run_cnt;
            hi_ok  <= 1'b0;
            if (run_cnt != LO_V) begin
              err      <= 1'b1;
              state    <= MEAS;
              good_cnt <= '0;
            end
          end else if (c_up && run_cnt == STUCK_V) begin
            err      <= 1'b1;
            state    <= MEAS;
            good_cnt <= '0;
          end
        end

        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_dclk_monitor.sv
// Directed checks of dclk_monitor with 4-high / 2-low expected duty and 2-period lock.
module tb_dclk_monitor;

  logic       clk;
  logic       rst_b;
  logic       clr;
  logic       c_up;
  logic       dclk_in;
  logic       rise;
  logic       fall;
  logic [3:0] hi_len;
  logic [3:0] lo_len;
  logic       locked;
  logic       err;

  int unsigned n_assert;
  int unsigned n_fail;

  dclk_monitor #(
    .W       (4),
    .EXP_HI  (4),
    .EXP_LO  (2),
    .LOCK_CNT(2)
  ) dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .clr    (clr),
    .c_up   (c_up),
    .dclk_in(dclk_in),
    .rise   (rise),
    .fall   (fall),
    .hi_len (hi_len),
    .lo_len (lo_len),
    .locked (locked),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, let the DUT sample them, settle just after the edge.
  task automatic step(input logic d, input logic cu);
    dclk_in = d;
    c_up    = cu;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic d, input int unsigned n, input logic cu);
    for (int unsigned i = 0; i < n; i++) step(d, cu);
  endtask

  // Ends right after the closing rise of a nominal 4-high/2-low period.
  task automatic good_period();
    run(1'b1, 3, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_rise"},   rise,   1'b0);
    chk1({tag, "_fall"},   fall,   1'b0);
    chkw({tag, "_hi_len"}, hi_len, 4'd0);
    chkw({tag, "_lo_len"}, lo_len, 4'd0);
    chk1({tag, "_locked"}, locked, 1'b0);
    chk1({tag, "_err"},    err,    1'b0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_b    = 1'b0;
    clr      = 1'b0;
    c_up     = 1'b1;
    dclk_in  = 1'b0;

    // Reset and first lock sequence
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_b = 1'b1;

    step(1'b1, 1'b1);
    chk1("first_rise", rise, 1'b1);
    chkw("first_rise_lo_no_capture", lo_len, 4'd0);
    run(1'b1, 3, 1'b1);
    step(1'b0, 1'b1);
    chk1("first_fall", fall, 1'b1);
    chkw("first_hi_len", hi_len, 4'd4);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chkw("first_lo_len", lo_len, 4'd2);
    chk1("not_locked_2nd_rise", locked, 1'b0);
    good_period();
    chk1("locked_3rd_rise", locked, 1'b1);
    chk1("err_clean_lock", err, 1'b0);

    // c_up held low for 3 cycles mid-high: run length pauses
    step(1'b1, 1'b1);
    run(1'b1, 3, 1'b0);
    chk1("hold_locked", locked, 1'b1);
    run(1'b1, 2, 1'b1);
    step(1'b0, 1'b1);
    chkw("hold_hi_len", hi_len, 4'd4);
    chk1("hold_locked_fall", locked, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chkw("hold_lo_len", lo_len, 4'd2);
    chk1("hold_err", err, 1'b0);

    // Stretched high: stuck check at run_cnt=4
    run(1'b1, 3, 1'b1);
    chk1("stretch_pre_err", err, 1'b0);
    chk1("stretch_pre_locked", locked, 1'b1);
    step(1'b1, 1'b1);
    chk1("stretch_err", err, 1'b1);
    chk1("stretch_unlocked", locked, 1'b0);
    step(1'b0, 1'b1);
    chkw("stretch_hi_len", hi_len, 4'd5);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk1("stretch_bad_period", locked, 1'b0);
    good_period();
    chk1("stretch_one_good", locked, 1'b0);
    good_period();
    chk1("stretch_relock", locked, 1'b1);
    chk1("stretch_err_sticky", err, 1'b1);

    // Clear while locked
    clr = 1'b1;
    step(1'b1, 1'b1);
    clr = 1'b0;
    chk_all_zero("clr");
    run(1'b1, 2, 1'b1);
    step(1'b0, 1'b1);
    chkw("clr_sync_fall_no_capture", hi_len, 4'd0);
    chk1("clr_no_false_err", err, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chkw("clr_first_lo_len", lo_len, 4'd2);
    chk1("clr_rise1_unlocked", locked, 1'b0);
    good_period();
    chk1("clr_rise2_unlocked", locked, 1'b0);
    good_period();
    chk1("clr_relock", locked, 1'b1);
    chk1("clr_err_clean", err, 1'b0);

    // Edge while c_up=0 (correct length, so only the protocol flag trips)
    run(1'b1, 3, 1'b1);
    step(1'b0, 1'b0);
    chk1("proto_err", err, 1'b1);
    chk1("proto_fall", fall, 1'b1);
    chkw("proto_hi_len", hi_len, 4'd4);
    chk1("proto_still_locked", locked, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chkw("proto_lo_len", lo_len, 4'd2);
    chk1("proto_locked_after", locked, 1'b1);

    // Asynchronous reset mid-period, then the startup lock sequence again
    run(1'b1, 2, 1'b1);
    #2;
    rst_b = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #2;
    dclk_in = 1'b1;
    rst_b   = 1'b1;
    @(posedge clk);
    #1;
    chk1("rst2_first_rise", rise, 1'b1);
    run(1'b1, 3, 1'b1);
    step(1'b0, 1'b1);
    chkw("rst2_hi_len", hi_len, 4'd4);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chkw("rst2_lo_len", lo_len, 4'd2);
    chk1("rst2_rise2_unlocked", locked, 1'b0);
    good_period();
    chk1("rst2_locked", locked, 1'b1);
    chk1("rst2_err", err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
